// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//  - arb_state_t : 2-bit arbiter FSM encoding
//  - PORT_C/PORT_X : read-return owner tags
package dmem_arb_pkg;

   localparam int unsigned ARB_STATE_W = 2;

   typedef enum logic [ARB_STATE_W-1:0] {
      ARB_IDLE     = 2'd0,   // last grant went to C, or no grant yet
      ARB_LAST_X   = 2'd1,   // last grant went to X, no burst
      ARB_X_LOCKED = 2'd2    // X is holding a locked burst
   } arb_state_t;

   localparam logic PORT_C = 1'b0;
   localparam logic PORT_X = 1'b1;

endpackage

// File: rtl/arb_lock_counter.sv
// Saturating count of consecutive locked X grants taken while the core waits.
// Ports:
//  clk, rst  : clock, synchronous active-high reset
//  clr       : clear the count (takes priority over inc)
//  inc       : count one more locked X grant
//  sat_c     : count has reached MAX_LOCK
module arb_lock_counter #(
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic sat_c
);

   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   logic [CNT_W-1:0] cnt_q;

   assign sat_c = (cnt_q == CNT_W'(MAX_LOCK));

   // Count register; holds at MAX_LOCK once saturated
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (clr)
         cnt_q <= '0;
      else if (inc && !sat_c)
         cnt_q <= cnt_q + CNT_W'(1);
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core
// load/store path (C) and an external loader/debug port (X), with an optional
// X burst lock that can starve the core for at most MAX_LOCK grants.
// Ports:
//  clk, rst                         : clock, synchronous active-high reset
//  c_req/c_we/c_addr/c_wdata        : core request
//  c_gnt/c_rvalid/c_rdata/core_stall: core response and stall
//  x_req/x_we/x_lock/x_addr/x_wdata : external request
//  x_gnt/x_rvalid/x_rdata           : external response
//  mem_en/mem_we/mem_addr/mem_wdata : memory request, mem_rdata 1 cycle later
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_LOCK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   output logic              core_stall,
   input  logic              x_req,
   input  logic              x_we,
   input  logic              x_lock,
   input  logic [ADDR_W-1:0] x_addr,
   input  logic [DATA_W-1:0] x_wdata,
   output logic              x_gnt,
   output logic              x_rvalid,
   output logic [DATA_W-1:0] x_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t state_q;
   arb_state_t state_d;
   logic       lock_sat;
   logic       lock_inc;
   logic       lock_clr;
   logic       rvalid_q;
   logic       rd_owner_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ARB_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state: follows the grant; a locked burst ends when X stops asking
   always_comb begin
      state_d = state_q;
      if (x_gnt)
         state_d = x_lock ? ARB_X_LOCKED : ARB_LAST_X;
      else if (c_gnt)
         state_d = ARB_IDLE;
      else if ((state_q == ARB_X_LOCKED) && !x_req)
         state_d = ARB_LAST_X;
   end

   // Outputs: grant decision, stall and memory-side mux
   always_comb begin
      c_gnt      = 1'b0;
      x_gnt      = 1'b0;
      // Requests seen during reset are ignored
      if (!rst) begin
         if ((state_q == ARB_X_LOCKED) && x_req && (!c_req || !lock_sat))
            x_gnt = 1'b1;
         else if (c_req && x_req) begin
            // Favour whoever was not served last
            if (state_q == ARB_IDLE)
               x_gnt = 1'b1;
            else
               c_gnt = 1'b1;
         end
         else if (c_req)
            c_gnt = 1'b1;
         else if (x_req)
            x_gnt = 1'b1;
      end
      core_stall = c_req && !c_gnt && !rst;
      mem_en     = c_gnt || x_gnt;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (c_gnt) begin
         mem_we    = c_we;
         mem_addr  = c_addr;
         mem_wdata = c_wdata;
      end
      else if (x_gnt) begin
         mem_we    = x_we;
         mem_addr  = x_addr;
         mem_wdata = x_wdata;
      end
   end

   // Starvation bound: only locked X grants taken while C waits are counted
   assign lock_inc = x_gnt && c_req && (state_q == ARB_X_LOCKED);
   assign lock_clr = c_gnt || ((state_q == ARB_X_LOCKED) && (state_d != ARB_X_LOCKED));

   arb_lock_counter #(
      .MAX_LOCK (MAX_LOCK)
   ) u_lock_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (lock_clr),
      .inc   (lock_inc),
      .sat_c (lock_sat)
   );

   // Read-return tracking: one outstanding load, tagged with its owner
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q   <= 1'b0;
         rd_owner_q <= PORT_C;
      end
      else begin
         rvalid_q   <= (c_gnt && !c_we) || (x_gnt && !x_we);
         rd_owner_q <= x_gnt ? PORT_X : PORT_C;
      end
   end

   // Gating with rst drops a read that was in flight when reset hit
   assign c_rvalid = rvalid_q && !rst && (rd_owner_q == PORT_C);
   assign x_rvalid = rvalid_q && !rst && (rd_owner_q == PORT_X);
   assign c_rdata  = c_rvalid ? mem_rdata : '0;
   assign x_rdata  = x_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: table vectors, directed
// multi-cycle sequences and random traffic against a rule-level model.
module tb_dmem_port_arbiter;

   localparam int unsigned MAX_LOCK = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_req = 1'b0, c_we = 1'b0, x_req = 1'b0, x_we = 1'b0, x_lock = 1'b0;
   logic [31:0] c_addr = '0, c_wdata = '0, x_addr = '0, x_wdata = '0;
   logic        c_gnt, c_rvalid, core_stall, x_gnt, x_rvalid, mem_en, mem_we;
   logic [31:0] c_rdata, x_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
      .x_req(x_req), .x_we(x_we), .x_lock(x_lock), .x_addr(x_addr), .x_wdata(x_wdata),
      .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Environment: 16-word memory with one-cycle read latency
   logic [31:0] env_mem [16];
   always @(posedge clk) begin
      if (mem_en && mem_we)
         env_mem[mem_addr[5:2]] <= mem_wdata;
      if (mem_en && !mem_we)
         mem_rdata <= env_mem[mem_addr[5:2]];
   end

   // Reference model state
   bit          m_last_x = 0;
   bit          m_locked = 0;
   int          m_run    = 0;
   bit          m_pend   = 0;
   bit          m_pend_x = 0;
   logic [31:0] m_pend_data = '0;
   logic [31:0] m_mem [16];

   int    n_chk  = 0;
   int    n_fail = 0;
   string tag    = "";

   // Captured DUT outputs of the last step
   logic        a_cg, a_xg, a_st, a_we, a_crv, a_xrv;
   logic [31:0] a_crd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, nm, act, exp);
      end
   endtask

   // One clock cycle: drive, check against model, then advance the model
   task automatic step(input logic r, input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic xr, input logic xw, input logic xl,
                       input logic [31:0] xa, input logic [31:0] xd);
      bit          e_cg, e_xg, e_crv, e_xrv, e_we;
      logic [31:0] e_addr, e_wd;
      @(negedge clk);
      rst = r; c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
      x_req = xr; x_we = xw; x_lock = xl; x_addr = xa; x_wdata = xd;
      #1;
      e_cg = 0; e_xg = 0;
      if (!r) begin
         if (m_locked && xr && (!cr || m_run < MAX_LOCK)) e_xg = 1;
         else if (cr && xr) begin
            if (m_last_x) e_cg = 1; else e_xg = 1;
         end
         else if (cr) e_cg = 1;
         else if (xr) e_xg = 1;
      end
      e_we   = e_cg ? cw : (e_xg ? xw : 1'b0);
      e_addr = e_cg ? ca : (e_xg ? xa : 32'h0);
      e_wd   = e_cg ? cd : (e_xg ? xd : 32'h0);
      e_crv  = !r && m_pend && !m_pend_x;
      e_xrv  = !r && m_pend && m_pend_x;
      a_cg = c_gnt; a_xg = x_gnt; a_st = core_stall; a_we = mem_we;
      a_crv = c_rvalid; a_xrv = x_rvalid; a_crd = c_rdata;
      chk("c_gnt",      32'(c_gnt),      32'(e_cg));
      chk("x_gnt",      32'(x_gnt),      32'(e_xg));
      chk("core_stall", 32'(core_stall), 32'(cr && !e_cg && !r));
      chk("mem_en",     32'(mem_en),     32'(e_cg || e_xg));
      chk("mem_we",     32'(mem_we),     32'(e_we));
      chk("mem_addr",   mem_addr,        e_addr);
      chk("mem_wdata",  mem_wdata,       e_wd);
      chk("c_rvalid",   32'(c_rvalid),   32'(e_crv));
      chk("x_rvalid",   32'(x_rvalid),   32'(e_xrv));
      chk("c_rdata",    c_rdata,         e_crv ? m_pend_data : 32'h0);
      chk("x_rdata",    x_rdata,         e_xrv ? m_pend_data : 32'h0);
      @(posedge clk);
      if (r) begin
         m_last_x = 0; m_locked = 0; m_run = 0; m_pend = 0; m_pend_x = 0;
      end
      else begin
         if (e_xg) begin
            if (m_locked && cr && m_run < MAX_LOCK) m_run++;
            if (!xl) m_run = 0;
            m_locked = xl;
            m_last_x = 1;
         end
         else if (e_cg) begin
            m_last_x = 0; m_locked = 0; m_run = 0;
         end
         else if (m_locked && !xr) begin
            m_locked = 0; m_run = 0;
         end
         m_pend   = (e_cg || e_xg) && !e_we;
         m_pend_x = e_xg;
         if (m_pend) m_pend_data = m_mem[e_addr[5:2]];
         if ((e_cg || e_xg) && e_we) m_mem[e_addr[5:2]] = e_wd;
      end
   endtask

   typedef struct {
      logic rst, cr, xr, xl;
      logic ecg, exg;
   } vec_t;

   vec_t vecs [16];

   initial begin
      for (int i = 0; i < 16; i++) begin
         env_mem[i] = '0;
         m_mem[i]   = '0;
      end
      //          rst cr xr xl  cg xg
      vecs[0]  = '{1, 1, 1, 0, 0, 0};  // reset holds off both requesters
      vecs[1]  = '{1, 1, 1, 0, 0, 0};
      vecs[2]  = '{0, 1, 1, 0, 0, 1};  // contention from idle: X first
      vecs[3]  = '{0, 1, 1, 0, 1, 0};
      vecs[4]  = '{0, 1, 1, 0, 0, 1};
      vecs[5]  = '{0, 1, 1, 0, 1, 0};
      vecs[6]  = '{0, 0, 1, 1, 0, 1};  // X opens a locked burst
      vecs[7]  = '{0, 1, 1, 1, 0, 1};  // locked grants 1..4 while core waits
      vecs[8]  = '{0, 1, 1, 1, 0, 1};
      vecs[9]  = '{0, 1, 1, 1, 0, 1};
      vecs[10] = '{0, 1, 1, 1, 0, 1};
      vecs[11] = '{0, 1, 1, 1, 1, 0};  // bound reached: core served
      vecs[12] = '{0, 0, 1, 1, 0, 1};  // X resumes
      vecs[13] = '{0, 0, 0, 0, 0, 0};  // burst dropped
      vecs[14] = '{0, 1, 1, 0, 1, 0};  // last was X: core wins
      vecs[15] = '{0, 0, 0, 0, 0, 0};

      for (int i = 0; i < 16; i++) begin
         tag = $sformatf("vec%0d", i);
         step(vecs[i].rst, vecs[i].cr, 1'b0, 32'h10, 32'h0,
              vecs[i].xr, 1'b0, vecs[i].xl, 32'h14, 32'h0);
         chk("tbl_c_gnt", 32'(a_cg), 32'(vecs[i].ecg));
         chk("tbl_x_gnt", 32'(a_xg), 32'(vecs[i].exg));
         chk("tbl_stall", 32'(a_st), 32'(vecs[i].cr && !vecs[i].ecg && !vecs[i].rst));
      end

      // Solo core load returns 0xDEADBEEF one cycle after grant
      tag = "solo";
      step(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h10, 32'hDEADBEEF);
      step(0, 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      chk("solo_gnt", 32'(a_cg), 32'd1);
      chk("solo_stall", 32'(a_st), 32'd0);
      step(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      chk("solo_rvalid", 32'(a_crv), 32'd1);
      chk("solo_rdata", a_crd, 32'hDEADBEEF);
      chk("solo_xrvalid", 32'(a_xrv), 32'd0);

      // X store then core load of the same word
      tag = "wr_rd";
      step(0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h20, 32'h55);
      chk("x_store_we", 32'(a_we), 32'd1);
      chk("x_store_xrv", 32'(a_xrv), 32'd0);
      step(0, 1, 0, 32'h20, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      chk("c_load_we", 32'(a_we), 32'd0);
      chk("c_load_xrv", 32'(a_xrv), 32'd0);
      step(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      chk("wr_rd_rvalid", 32'(a_crv), 32'd1);
      chk("wr_rd_rdata", a_crd, 32'h55);
      chk("wr_rd_xrv", 32'(a_xrv), 32'd0);

      // Reset lands while a core load is in flight
      tag = "rst_rd";
      step(0, 1, 0, 32'h20, 32'h0, 0, 0, 0, 32'h0, 32'h0);
      chk("rst_rd_gnt", 32'(a_cg), 32'd1);
      step(1, 1, 0, 32'h20, 32'h0, 1, 0, 0, 32'h24, 32'h0);
      chk("rst_rd_rvalid", 32'(a_crv), 32'd0);
      chk("rst_rd_cg", 32'(a_cg), 32'd0);
      step(0, 1, 0, 32'h20, 32'h0, 1, 0, 0, 32'h24, 32'h0);
      chk("rst_rd_idle_x", 32'(a_xg), 32'd1);
      chk("rst_rd_late", 32'(a_crv), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         tag = $sformatf("rnd%0d", i);
         step(($urandom_range(0, 39) == 0),
              1'($urandom), 1'($urandom), $urandom, $urandom,
              1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
